// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer (master) and the R/I-type datapath (slave).
// Carries the opcode and zero flag upstream, and all control strobes plus status downstream.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic             zero;
    logic             RegDst;
    logic             ALUSrc;
    logic             Mem2Reg;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic             PCSrc;
    logic             push;
    logic             pop;
    logic [4:0]       ALUOp;
    logic             halt;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    modport master (
        input  op, zero,
        output RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc, push, pop,
        output ALUOp, halt, illegal, retired, state
    );

    modport slave (
        output op, zero,
        input  RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc, push, pop,
        input  ALUOp, halt, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-cycle datapath.
// All datapath controls are registered from the next-state view, so they change only on clk or reset.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BOOT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEM    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALTED = 3'd7;

    localparam logic [3:0] C_NONE = 4'd0;
    localparam logic [3:0] C_R    = 4'd1;
    localparam logic [3:0] C_I    = 4'd2;
    localparam logic [3:0] C_LW   = 4'd3;
    localparam logic [3:0] C_SW   = 4'd4;
    localparam logic [3:0] C_BZ   = 4'd5;
    localparam logic [3:0] C_BNZ  = 4'd6;
    localparam logic [3:0] C_JMP  = 4'd7;
    localparam logic [3:0] C_CALL = 4'd8;
    localparam logic [3:0] C_RET  = 4'd9;
    localparam logic [3:0] C_HALT = 4'd10;
    localparam logic [3:0] C_ILL  = 4'd11;

    typedef struct packed {
        logic [3:0] cls;
        logic [4:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem2reg;
    } dec_t;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem2reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
        logic       push;
        logic       pop;
        logic [4:0] alu_op;
        logic       halt;
    } ctl_t;

    function automatic dec_t dec_clear();
        dec_t d;
        d.cls     = C_NONE;
        d.alu_op  = 5'd0;
        d.reg_dst = 1'b0;
        d.alu_src = 1'b0;
        d.mem2reg = 1'b0;
        return d;
    endfunction

    function automatic dec_t decode_op(input logic [5:0] op_v);
        dec_t d;
        d = dec_clear();
        case (op_v[5:4])
            2'b00: begin
                d.cls     = C_R;
                d.alu_op  = {1'b0, op_v[3:0]};
                d.reg_dst = 1'b1;
            end
            2'b01: begin
                d.cls     = C_I;
                d.alu_op  = {1'b0, op_v[3:0]};
                d.alu_src = 1'b1;
            end
            default: begin
                case (op_v)
                    6'b100000: begin
                        d.cls     = C_LW;
                        d.alu_src = 1'b1;
                        d.mem2reg = 1'b1;
                    end
                    6'b100001: begin
                        d.cls     = C_SW;
                        d.alu_src = 1'b1;
                    end
                    6'b100010: begin
                        d.cls    = C_BZ;
                        d.alu_op = 5'd1;
                    end
                    6'b100011: begin
                        d.cls    = C_BNZ;
                        d.alu_op = 5'd1;
                    end
                    6'b100100: d.cls = C_JMP;
                    6'b100101: d.cls = C_CALL;
                    6'b100110: d.cls = C_RET;
                    6'b111111: d.cls = C_HALT;
                    default:   d.cls = C_ILL;
                endcase
            end
        endcase
        return d;
    endfunction

    function automatic ctl_t ctl_idle();
        ctl_t c;
        c.reg_dst   = 1'b0;
        c.alu_src   = 1'b0;
        c.mem2reg   = 1'b0;
        c.mem_read  = 1'b0;
        c.mem_write = 1'b0;
        c.reg_write = 1'b0;
        c.pc_src    = 1'b0;
        c.push      = 1'b0;
        c.pop       = 1'b0;
        c.alu_op    = 5'd0;
        c.halt      = 1'b1;
        return c;
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    dec_t             dec_r;
    dec_t             dec_nxt_s;
    logic             taken_r;
    logic             taken_nxt_s;
    ctl_t             ctl_r;
    ctl_t             ctl_nxt_s;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;

    // State, decode latch, branch flag, registered controls and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            dec_r     <= dec_clear();
            taken_r   <= 1'b0;
            ctl_r     <= ctl_idle();
            illegal_r <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            dec_r     <= dec_nxt_s;
            taken_r   <= taken_nxt_s;
            ctl_r     <= ctl_nxt_s;
            illegal_r <= illegal_r | ((state_r == S_DECODE) && (dec_nxt_s.cls == C_ILL));
            if (state_r == S_WB) begin
                retired_r <= retired_r + CNT_W'(1'b1);
            end
        end
    end

    // Next-state sequencing; memory instructions take the extra MEM step.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE:   state_nxt_s = S_BOOT;
            S_BOOT:   state_nxt_s = S_FETCH;
            S_FETCH:  state_nxt_s = S_DECODE;
            S_DECODE: state_nxt_s = (decode_op(bus.op).cls == C_HALT) ? S_HALTED : S_EXEC;
            S_EXEC:   state_nxt_s = ((dec_r.cls == C_LW) || (dec_r.cls == C_SW)) ? S_MEM : S_WB;
            S_MEM:    state_nxt_s = S_WB;
            S_WB:     state_nxt_s = S_FETCH;
            S_HALTED: state_nxt_s = S_HALTED;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Decode latch and zero capture, presented as next values so controls can be registered.
    always_comb begin
        dec_nxt_s   = dec_r;
        taken_nxt_s = taken_r;
        if (state_r == S_DECODE) begin
            dec_nxt_s = decode_op(bus.op);
        end else if (state_nxt_s == S_FETCH) begin
            dec_nxt_s = dec_clear();
        end else begin
            dec_nxt_s = dec_r;
        end
        if (state_r == S_EXEC) begin
            taken_nxt_s = bus.zero;
        end else begin
            taken_nxt_s = taken_r;
        end
    end

    // Control outputs for the upcoming state; only BOOT and WB drop halt.
    always_comb begin
        ctl_nxt_s = ctl_idle();
        case (state_nxt_s)
            S_BOOT: ctl_nxt_s.halt = 1'b0;
            S_EXEC, S_MEM, S_WB: begin
                ctl_nxt_s.alu_op  = dec_nxt_s.alu_op;
                ctl_nxt_s.reg_dst = dec_nxt_s.reg_dst;
                ctl_nxt_s.alu_src = dec_nxt_s.alu_src;
                ctl_nxt_s.mem2reg = dec_nxt_s.mem2reg;
                if (state_nxt_s == S_MEM) begin
                    ctl_nxt_s.mem_read  = (dec_nxt_s.cls == C_LW);
                    ctl_nxt_s.mem_write = (dec_nxt_s.cls == C_SW);
                end else if (state_nxt_s == S_WB) begin
                    ctl_nxt_s.halt      = 1'b0;
                    ctl_nxt_s.mem_read  = (dec_nxt_s.cls == C_LW);
                    ctl_nxt_s.reg_write = (dec_nxt_s.cls == C_R) || (dec_nxt_s.cls == C_I) ||
                                          (dec_nxt_s.cls == C_LW);
                    ctl_nxt_s.pc_src    = ((dec_nxt_s.cls == C_BZ) && taken_nxt_s) ||
                                          ((dec_nxt_s.cls == C_BNZ) && !taken_nxt_s) ||
                                          (dec_nxt_s.cls == C_JMP) || (dec_nxt_s.cls == C_CALL);
                    ctl_nxt_s.push      = (dec_nxt_s.cls == C_CALL);
                    ctl_nxt_s.pop       = (dec_nxt_s.cls == C_RET);
                end else begin
                    ctl_nxt_s.mem_read = 1'b0;
                end
            end
            default: ctl_nxt_s = ctl_idle();
        endcase
    end

    assign bus.RegDst   = ctl_r.reg_dst;
    assign bus.ALUSrc   = ctl_r.alu_src;
    assign bus.Mem2Reg  = ctl_r.mem2reg;
    assign bus.MemRead  = ctl_r.mem_read;
    assign bus.MemWrite = ctl_r.mem_write;
    assign bus.RegWrite = ctl_r.reg_write;
    assign bus.PCSrc    = ctl_r.pc_src;
    assign bus.push     = ctl_r.push;
    assign bus.pop      = ctl_r.pop;
    assign bus.ALUOp    = ctl_r.alu_op;
    assign bus.halt     = ctl_r.halt;
    assign bus.illegal  = illegal_r;
    assign bus.retired  = retired_r;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction phase model pushes expected
// cycle records; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic [2:0]    state;
        logic          halt;
        logic          reg_dst;
        logic          alu_src;
        logic          mem2reg;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          pc_src;
        logic          push;
        logic          pop;
        logic [4:0]    alu_op;
        logic          illegal;
        logic [CW-1:0] retired;
    } exp_t;

    typedef enum int {K_ALU, K_LW, K_SW, K_BZ, K_BNZ, K_JMP, K_CALL, K_RET, K_HALT, K_BAD} kind_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   ncyc;
    exp_t sb[$];
    logic          m_illegal;
    logic [CW-1:0] m_retired;

    multicycle_ctrl_if #(.CNT_W(CW)) bus();

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sample_dut();
        exp_t g;
        g.state     = bus.state;
        g.halt      = bus.halt;
        g.reg_dst   = bus.RegDst;
        g.alu_src   = bus.ALUSrc;
        g.mem2reg   = bus.Mem2Reg;
        g.mem_read  = bus.MemRead;
        g.mem_write = bus.MemWrite;
        g.reg_write = bus.RegWrite;
        g.pc_src    = bus.PCSrc;
        g.push      = bus.push;
        g.pop       = bus.pop;
        g.alu_op    = bus.ALUOp;
        g.illegal   = bus.illegal;
        g.retired   = bus.retired;
        return g;
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic h);
        exp_t e;
        e = '0;
        e.state   = st;
        e.halt    = h;
        e.illegal = m_illegal;
        e.retired = m_retired;
        return e;
    endfunction

    function automatic kind_t kind_of(input logic [5:0] op_v);
        if (op_v[5:4] == 2'b00 || op_v[5:4] == 2'b01) return K_ALU;
        case (op_v)
            6'h20:   return K_LW;
            6'h21:   return K_SW;
            6'h22:   return K_BZ;
            6'h23:   return K_BNZ;
            6'h24:   return K_JMP;
            6'h25:   return K_CALL;
            6'h26:   return K_RET;
            6'h3f:   return K_HALT;
            default: return K_BAD;
        endcase
    endfunction

    // Monitor: every sampled cycle with an outstanding expectation is compared.
    always @(negedge clk) begin
        exp_t g;
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = sample_dut();
            checks++;
            ncyc++;
            if (g !== e) begin
                failures++;
                $display("FAIL trace#%0d state got=%0d exp=%0d vec got=%h exp=%h", ncyc, g.state, e.state, g, e);
            end
        end
    end

    task automatic cycle(input logic [5:0] op_v, input logic z_v, input exp_t e);
        @(posedge clk);
        #1;
        bus.op   = op_v;
        bus.zero = z_v;
        sb.push_back(e);
    endtask

    task automatic boot();
        cycle(6'($urandom()), 1'($urandom()), mk(3'd1, 1'b0));
    endtask

    // One instruction; stop >= 0 ends it after that phase index (for mid-instruction reset).
    task automatic run_instr(input logic [5:0] op_v, input logic zx, input int stop);
        kind_t      k;
        logic [2:0] ph[$];
        exp_t       e;
        logic [5:0] opv;
        logic       zv;
        k  = kind_of(op_v);
        ph = '{3'd2, 3'd3};
        if (k != K_HALT) begin
            ph.push_back(3'd4);
            if (k == K_LW || k == K_SW) ph.push_back(3'd5);
            ph.push_back(3'd6);
        end
        for (int i = 0; i < ph.size(); i++) begin
            e = mk(ph[i], (ph[i] == 3'd6) ? 1'b0 : 1'b1);
            if (ph[i] >= 3'd4) begin
                e.alu_op  = (k == K_ALU) ? {1'b0, op_v[3:0]} : ((k == K_BZ || k == K_BNZ) ? 5'd1 : 5'd0);
                e.reg_dst = (k == K_ALU) && (op_v[5:4] == 2'b00);
                e.alu_src = ((k == K_ALU) && (op_v[5:4] == 2'b01)) || k == K_LW || k == K_SW;
                e.mem2reg = (k == K_LW);
            end
            if (ph[i] == 3'd5) begin
                e.mem_read  = (k == K_LW);
                e.mem_write = (k == K_SW);
            end
            if (ph[i] == 3'd6) begin
                e.mem_read  = (k == K_LW);
                e.reg_write = (k == K_ALU || k == K_LW);
                e.pc_src    = (k == K_JMP || k == K_CALL) || (k == K_BZ && zx) || (k == K_BNZ && !zx);
                e.push      = (k == K_CALL);
                e.pop       = (k == K_RET);
            end
            opv = (ph[i] == 3'd3) ? op_v : 6'($urandom());
            zv  = (ph[i] == 3'd4) ? zx : ((ph[i] > 3'd4) ? ~zx : 1'($urandom()));
            cycle(opv, zv, e);
            if (ph[i] == 3'd3 && k == K_BAD) m_illegal = 1'b1;
            if (ph[i] == 3'd6) m_retired = m_retired + 1'b1;
            if (i == stop) return;
        end
    endtask

    task automatic check_reset(input string name);
        exp_t g;
        exp_t e;
        e = '0;
        e.halt = 1'b1;
        g = sample_dut();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges, then release and BOOT.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset(name);
        @(posedge clk);
        @(negedge clk);
        check_reset({name, "_held"});
        reset     = 1'b1;
        m_illegal = 1'b0;
        m_retired = '0;
        boot();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rop;
        checks    = 0;
        failures  = 0;
        ncyc      = 0;
        m_illegal = 1'b0;
        m_retired = '0;
        bus.op    = 6'd0;
        bus.zero  = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        @(negedge clk);
        reset = 1'b1;
        boot();
        repeat (3) run_instr(6'b000000, 1'($urandom()), -1);
        run_instr(6'b100000, 1'b0, -1);
        run_instr(6'b100001, 1'b1, -1);
        run_instr(6'b100010, 1'b1, -1);
        run_instr(6'b100011, 1'b1, -1);
        run_instr(6'b100101, 1'b0, -1);
        run_instr(6'b100110, 1'b0, -1);
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 9))
                0:       rop = {2'b00, 4'($urandom())};
                1:       rop = {2'b01, 4'($urandom())};
                2:       rop = 6'h20;
                3:       rop = 6'h21;
                4:       rop = 6'h22;
                5:       rop = 6'h23;
                6:       rop = 6'h24;
                7:       rop = 6'h25;
                8:       rop = 6'h26;
                default: rop = {2'b01, 4'($urandom())};
            endcase
            run_instr(rop, 1'($urandom()), -1);
        end
        run_instr(6'b101111, 1'b0, -1);
        run_instr(6'b010011, 1'b1, -1);
        run_instr(6'b111111, 1'b0, -1);
        repeat (6) cycle(6'($urandom()), 1'($urandom()), mk(3'd7, 1'b1));
        pulse_reset("reset_from_halted");
        run_instr(6'b000101, 1'b0, -1);
        run_instr(6'b100000, 1'b0, 3);
        pulse_reset("reset_mid_lw");
        run_instr(6'b100010, 1'b0, -1);
        run_instr({2'b10, 4'($urandom_range(7, 15))}, 1'b1, -1);
        run_instr(6'b100100, 1'b1, -1);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer that sits directly upstream of the single-cycle R/I-type datapath. It decodes the 6-bit opcode the datapath returns, steps each instruction through FETCH/DECODE/EXEC/MEM/WB states, and drives all datapath control lines. It holds `halt` high on every cycle except a single commit cycle per instruction, so the datapath's PC, stack and register bank advance exactly once per instruction.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `op`  in  6  opcode, `instr[31:26]`, from the datapath.
- `zero`  in  1  ALU zero flag from the datapath.
- `RegDst`, `ALUSrc`, `Mem2Reg`, `MemRead`, `MemWrite`, `RegWrite`, `PCSrc`, `push`, `pop`  out  1 each  datapath controls.
- `ALUOp`  out  5  ALU function select.
- `halt`  out  1  1 = datapath frozen; 0 = commit cycle.
- `illegal`  out  1  sticky flag, set when an undefined opcode is decoded.
- `retired`  out  CNT_W  count of committed instructions; wraps modulo 2^CNT_W.
- `state`  out  3  current state, for debug.

## Operation
- States: IDLE=0, BOOT=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALTED=7.
- Reset (`reset`=0): state=IDLE, decode registers cleared, `illegal`=0, `retired`=0. All outputs are 0 except `halt`=1.
- State transitions:
  - IDLE→BOOT on the first clock after reset is released.
  - BOOT is a commit with no writes: `halt`=0 for one cycle to step the PC from -4 to 0. BOOT→FETCH.
  - FETCH→DECODE.
  - DECODE latches the class, `ALUOp`, `RegDst`, `ALUSrc` and `Mem2Reg` from `op`. HALT goes to HALTED; all other opcodes go to EXEC.
  - EXEC samples `zero` into `taken`. LW/SW go to MEM; all others go to WB.
  - MEM→WB.
  - WB is the commit cycle, then WB→FETCH.
  - HALTED is terminal until reset; `halt`=1.
- Opcode map:
  - `op[5:4]`=00: R-type. `ALUOp`={0,`op[3:0]`}, `RegDst`=1, `ALUSrc`=0, `RegWrite` in WB.
  - `op[5:4]`=01: immediate. `ALUOp`={0,`op[3:0]`}, `RegDst`=0, `ALUSrc`=1, `RegWrite` in WB.
  - 100000 LW: `ALUOp`=00000 (add), `ALUSrc`=1, `RegDst`=0, `Mem2Reg`=1. `MemRead` in MEM and WB; `RegWrite` in WB.
  - 100001 SW: `ALUOp`=00000, `ALUSrc`=1. `MemWrite` in MEM only.
  - 100010 BZ / 100011 BNZ: `ALUOp`=00001 (sub), `ALUSrc`=0. `PCSrc` in WB = `taken` for BZ, `~taken` for BNZ.
  - 100100 JMP: `PCSrc`=1 in WB.
  - 100101 CALL: `push`=1 and `PCSrc`=1 in WB.
  - 100110 RET: `pop`=1 in WB.
  - 111111 HALT.
  - Any other opcode: executes as a NOP through WB with no writes, and sets `illegal`.
- Latched controls (`ALUOp`, `RegDst`, `ALUSrc`, `Mem2Reg`) are valid from DECODE+1 through WB and are zeroed in FETCH.
- Write strobes `RegWrite`, `push`, `pop` and `PCSrc` are asserted only while `halt`=0.
- `retired` increments on every WB, including illegal opcodes, but not on BOOT.

## Timing
- Latency: ALU, branch, jump, call and return instructions take 4 cycles (FETCH, DECODE, EXEC, WB). LW and SW take 5.
- First instruction: FETCH occurs on the 3rd clock after `reset` rises.
- `halt`=0 for exactly one cycle per instruction. The datapath's falling-edge PC update falls inside that cycle.
- `zero` is captured only at the end of EXEC; changes in MEM or WB are ignored.
- `reset` asserted mid-instruction: outputs go to their reset values immediately, with no clock needed. Any write in progress is dropped.
- `retired` rolls over from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Reset release, `op`=000000 stream → `halt` low in BOOT (cycle 2), then low every 4th cycle. `RegWrite`=`RegDst`=1 only in WB; `retired`=3 after 3 instructions.
- `op`=100000 (LW) → `state` follows 2,3,4,5,6. `MemRead` is 1 in states 5 and 6; `Mem2Reg`=1; `RegWrite` is 1 in state 6 only; latency 5.
- `op`=100001 (SW) → `MemWrite`=1 for exactly one cycle in state 5; `RegWrite` is never 1.
- BZ with `zero`=1 in EXEC then `zero`=0 in WB → `PCSrc`=1 in WB. BNZ under the same stimulus → `PCSrc`=0.
- CALL then RET → `push`=`PCSrc`=1 in the first WB; `pop`=1 in the second WB.
- `op`=101111 → `illegal`=1 and stays set, no writes. Then `op`=111111 → `state`=7 and `halt`=1 forever. Pulsing `reset` low asynchronously → IDLE with `illegal`=0 and `retired`=0.
